// File: rtl/serial_subtractor_if.sv
// Start/ready/done handshake and operand/result bus for serial_subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
// Optional SERIAL_SUBTRACTOR_SAT_EN: underflowing results are floored to zero.
//
// state | meaning
// IDLE  | ready for a new operation; start loads the operands
// RUN   | one difference bit per cycle, WIDTH cycles
// DONE  | one-cycle done pulse; diff/borrow just updated
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  serial_subtractor_if.slave bus_io
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             borrow_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_d;
  logic             last_bit;

  always_comb begin
    d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_d    = {d_bit, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    diff_d   = br_d ? '0 : res_d;
`else
    diff_d   = res_d;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus_io.start) begin
            a_q     <= bus_io.a;
            b_q     <= bus_io.b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          br_q  <= br_d;
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          // Result registers only move on the final bit so they hold across a later RUN
          if (last_bit) begin
            diff_q   <= diff_d;
            borrow_q <= br_d;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.ready  = ready_q;
  assign bus_io.busy   = busy_q;
  assign bus_io.done   = done_q;
  assign bus_io.diff   = diff_q;
  assign bus_io.borrow = borrow_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, with a registered borrow. It is the sequential counterpart to the team's combinational full adder: same per-bit sum/carry structure, run in the subtract direction through a single full-subtractor cell. It trades WIDTH+2 cycles of latency for one-bit datapath area and sits behind a start/ready/done handshake for use by slow control-path arithmetic.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; accepted only when `ready`=1.
- `a` input WIDTH: minuend, sampled on an accepted `start`.
- `b` input WIDTH: subtrahend, sampled on an accepted `start`.
- `ready` output 1: high only in IDLE.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse when the result is valid.
- `diff` output WIDTH: registered result `a - b` mod 2^WIDTH.
- `borrow` output 1: registered final borrow; 1 iff `a < b` unsigned.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE, `ready`=1, `busy`=0, `done`=0, `diff`=0, `borrow`=0. The borrow flop, bit counter and shift registers are all cleared.
- IDLE: if `start`=1, load `a` and `b` into working shift registers, clear the borrow flop, set the bit counter to 0, and go to RUN. Otherwise stay in IDLE.
- RUN, one bit per cycle, using the LSBs `a0` and `b0` of the working registers and the borrow flop `br`:
  - `d = a0 ^ b0 ^ br`
  - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`
  - Shift `d` into the MSB of the result shift register.
  - Shift both operand registers right by one.
  - Increment the counter.
- After bit WIDTH-1 is processed, go to DONE. In the same edge, copy the result shift register to `diff` and `br_next` to `borrow`.
- DONE: `done`=1 for exactly this one cycle, then unconditionally return to IDLE. `start` is ignored in DONE.
- `diff` and `borrow` hold their values from one DONE entry until the next DONE entry or reset. They do not change during a subsequent RUN.
- `start` while in RUN or DONE is ignored. Input operands are not re-sampled.
- `a` and `b` may change freely after acceptance.
- Reset mid-RUN or in DONE aborts the operation. Outputs take their reset values on the next edge, and no `done` pulse is emitted for the aborted operation.
- Arithmetic is unsigned modulo 2^WIDTH. The signed interpretation of `diff` is valid two's complement; signed overflow is not flagged.

## Timing
- Cycle T: `start`=1 and `ready`=1 sampled at the rising edge ending T.
- Cycles T+1 .. T+WIDTH: RUN, with `busy`=1 and `ready`=0.
- Cycle T+WIDTH+1: DONE, with `done`=1 and `diff`/`borrow` valid.
- Cycle T+WIDTH+2: IDLE, `ready`=1. The earliest next accept is at the end of this cycle.
- Throughput: one operation per WIDTH+2 cycles with `start` held high.
- There are no combinational paths from inputs to outputs. All outputs are registered or decoded directly from state.

## Configuration
- Macro: `SERIAL_SUBTRACTOR_SAT_EN`.
- Defined: on DONE entry, if the final borrow is 1, `diff` is loaded with 0 (unsigned floor saturation). `borrow` still reports 1.
- Undefined: `diff` is the wrapped modulo result. Timing and handshake are identical in both builds.

## Test plan
All scenarios use WIDTH=8.
- Basic subtract: reset, then start with a=0x5A, b=0x23 -> `done` pulse exactly 9 cycles after the start cycle; `diff`=0x37, `borrow`=0.
- Underflow: a=0x10, b=0x20 -> without the macro, `diff`=0xF0, `borrow`=1; with `SERIAL_SUBTRACTOR_SAT_EN`, `diff`=0x00, `borrow`=1.
- Boundaries:
  - a=0xFF, b=0xFF -> `diff`=0x00, `borrow`=0.
  - a=0x00, b=0x01 -> `diff`=0xFF (0x00 when saturated), `borrow`=1.
  - a=0x80, b=0x00 -> `diff`=0x80, `borrow`=0.
- Start while busy: start with a=0x40, b=0x01; 3 cycles later pulse start with a=0x00, b=0xFF -> only one `done`, `diff`=0x3F, `borrow`=0; `ready` stays 0 throughout RUN and DONE.
- Reset mid-run: assert `rst` for one cycle 4 cycles into RUN -> next cycle state is IDLE with `ready`=1, `busy`=0, `diff`=0, `borrow`=0; no `done` pulse follows.
- Back-to-back: hold `start`=1 with a=0x09, b=0x03, then a=0x03, b=0x09 -> `done` pulses 10 cycles apart; results are 0x06/0 then 0xFA/1 (0x00/1 when saturated); `diff` holds 0x06 throughout the second RUN.
